encrypter_out: RTL and testbench
================================

Name: encrypter_out

Overview:
Output side of the crypt datapath. Collects 32-bit result words from the FME core and serializes each one MSB-first into bytes for the UART transmitter. The framing matches what the input side expects: an optional 32-bit word-count header, then the payload words, 4 bytes each. Sits between the FME result port and the UART TX byte interface.

Parameters:
WORD_W, 32, FME word width; must be a multiple of 8
LEN_W, 32, width of the message-length and words-sent counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a message; honoured only in IDLE
msg_len  input  LEN_W  number of payload words; sampled on accepted start
fme_done  input  1  one-cycle pulse; fme_data_out is valid
fme_data_out  input  WORD_W  FME result word
word_ready  output  1  holding register empty; FME may deliver a word
tx_busy  input  1  UART transmitter busy
tx_start  output  1  one-cycle pulse; load tx_data into the transmitter
tx_data  output  8  byte to transmit
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last byte's tx_busy falls
overrun  output  1  sticky; fme_done arrived while word_ready was 0; cleared on start or rst

Behaviour:
- Reset values: tx_start=0, tx_data=0, word_ready=0, busy=0, done=0, overrun=0. FSM goes to IDLE; counters, holding register and shifter are cleared.
- Buffering is a double buffer: a holding register (hold, hold_valid) feeding a shifter (shift, byte_cnt 0..3).
- word_ready = busy & ~hold_valid & (words_accepted < msg_len).
- On fme_done with word_ready=1: hold <= fme_data_out, hold_valid <= 1, words_accepted++.
- On fme_done with word_ready=0: the word is dropped and overrun <= 1.
- FSM states:
  - IDLE: on start, latch msg_len, clear counters, clear overrun, busy <= 1. Next state is HDR if the header is compiled in, else LOAD.
  - HDR: place msg_len in the shifter, then go to SEND.
  - LOAD: if words_sent == msg_len, go to FIN. Otherwise, if hold_valid, move hold to the shifter, set hold_valid <= 0, words_sent++, go to SEND.
  - SEND: tx_start=1 for exactly one cycle, tx_data = shift[WORD_W-1 -: 8]. The shifter shifts left 8, byte_cnt++. Go to GUARD.
  - GUARD: exactly one cycle; tx_busy is ignored here to cover the transmitter's busy-assert latency. Go to DRAIN.
  - DRAIN: wait until tx_busy==0. Then go to SEND if byte_cnt != 0 (more bytes in this word), else LOAD.
  - FIN: done=1 for one cycle, busy <= 0, go to IDLE.
- Byte order: MSB first per word; words are sent in arrival order.
- Latency: a word in hold while in LOAD with tx idle gives tx_start 2 cycles later (LOAD, then SEND).
- Byte spacing: minimum 3 cycles between tx_start pulses (SEND, GUARD, DRAIN).
- The hold register refills while the shifter is still transmitting, so the FME runs concurrently with TX.
- msg_len==0:
  - Header on: sends 4 zero bytes, then done.
  - Header off: done pulses 2 cycles after start (LOAD, then FIN).
- start while busy is ignored. fme_done in IDLE is ignored; it does not set overrun.
- rst mid-message aborts immediately. No partial byte is issued after reset; tx_start is 0 in the cycle after rst.

Optional Feature:
CRYPT_OUT_HEADER_EN: defined means the 32-bit msg_len is sent first as 4 bytes, MSB first, mirroring the receiver framing. Undefined means the HDR state is absent and only payload bytes are sent (IDLE goes directly to LOAD).

Decomposition:
- Package crypt_pkg holds:
  - WORD_W = 32 and BYTES_PER_WORD = WORD_W/8
  - the encrypter_out state enum (IDLE, HDR, LOAD, SEND, GUARD, DRAIN, FIN)
- Sub-module word_serializer: a load/shift register with byte_cnt and a last_byte flag, reusable by other TX paths.

Test Plan:
- Header on: start with msg_len=2, words 0xDEADBEEF and 0x01020304, tx_busy held 10 cycles per byte. Expect tx_data sequence 00 00 00 02 DE AD BE EF 01 02 03 04, then one done pulse and busy=0.
- Header off: msg_len=1, word 0xA5A5_0F0F delivered while tx idle. Expect tx_start exactly 2 cycles after the word enters hold, bytes A5 A5 0F 0F, then done.
- Overrun: a second fme_done while hold_valid=1. Expect overrun=1, the second word absent from the TX stream, and overrun cleared by the next start.
- msg_len=0 with header off: start gives done 2 cycles later with no tx_start. With header on: 4 zero bytes, then done.
- Reset mid-word (after 2 of 4 bytes): assert rst. Expect tx_start=0, busy=0, word_ready=0 next cycle; a fresh start then transmits from the header/first byte.
- tx_busy asserted 1 cycle late, and start pulsed while busy: no byte is skipped or duplicated, and the extra start is ignored.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared definitions for the crypt datapath: word geometry and the encrypter_out FSM states.
package crypt_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    GUARD = 3'd4,
    DRAIN = 3'd5,
    FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/encrypter_out_word_serializer.sv
// word_serializer: parallel-load, shift-left-by-byte register with a byte counter;
// the top byte is always the next byte to transmit (MSB first).
module word_serializer #(
  parameter  int unsigned WORD_W = 32,
  localparam int unsigned NBYTES = WORD_W / 8,
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic [7:0]        top_byte_c,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              last_byte_c
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  assign top_byte_c  = shift_q[WORD_W-1 -: 8];
  assign last_byte_c = (byte_cnt_q == CNT_W'(NBYTES - 1));
  assign byte_cnt    = byte_cnt_q;

  // Load wins over shift; the counter wraps to zero once the last byte has gone.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (load) begin
      shift_d    = load_data;
      byte_cnt_d = '0;
    end else if (shift) begin
      shift_d    = shift_q << 8;
      byte_cnt_d = last_byte_c ? '0 : byte_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/encrypter_out.sv
// encrypter_out: buffers FME result words and serializes them MSB-first onto the UART TX
// byte interface. Define CRYPT_OUT_HEADER_EN to prefix each message with its 32-bit length.
module encrypter_out #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              fme_done,
  input  logic [WORD_W-1:0] fme_data_out,
  output logic              word_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  import crypt_pkg::*;

  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              word_ready_q, word_ready_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d;

  logic              ser_load, ser_shift;
  logic [WORD_W-1:0] ser_data;
  logic [7:0]        ser_top_c;
  logic [CNT_W-1:0]  ser_cnt;
  logic              unused_ser_last;

  word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (ser_load),
    .load_data   (ser_data),
    .shift       (ser_shift),
    .top_byte_c  (ser_top_c),
    .byte_cnt    (ser_cnt),
    .last_byte_c (unused_ser_last)
  );

  // Next-state, buffer and counter logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    acc_d        = acc_q;
    sent_d       = sent_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_data     = '0;

    // Holding register fills independently of the shifter; idle-state deliveries are ignored.
    if (fme_done) begin
      if (word_ready_q) begin
        hold_d       = fme_data_out;
        hold_valid_d = 1'b1;
        acc_d        = acc_q + LEN_W'(1);
      end else if (busy_q) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = msg_len;
          acc_d        = '0;
          sent_d       = '0;
          hold_valid_d = 1'b0;
          overrun_d    = 1'b0;
          busy_d       = 1'b1;
`ifdef CRYPT_OUT_HEADER_EN
          state_d      = HDR;
`else
          state_d      = LOAD;
`endif
        end
      end
`ifdef CRYPT_OUT_HEADER_EN
      HDR: begin
        ser_load = 1'b1;
        ser_data = WORD_W'(len_q);
        state_d  = SEND;
      end
`endif
      LOAD: begin
        if (sent_q == len_q) begin
          state_d = FIN;
        end else if (hold_valid_q) begin
          ser_load     = 1'b1;
          ser_data     = hold_q;
          hold_valid_d = 1'b0;
          sent_d       = sent_q + LEN_W'(1);
          state_d      = SEND;
        end
      end
      SEND: begin
        ser_shift = 1'b1;
        state_d   = GUARD;
      end
      // One dead cycle so the transmitter has time to raise tx_busy.
      GUARD: state_d = DRAIN;
      DRAIN: begin
        if (!tx_busy) state_d = (ser_cnt != '0) ? SEND : LOAD;
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    tx_start_d   = (state_d == SEND);
    done_d       = (state_d == FIN);
    tx_data_d    = tx_data_q;
    if (state_d == SEND) tx_data_d = ser_load ? ser_data[WORD_W-1 -: 8] : ser_top_c;
    word_ready_d = busy_d & ~hold_valid_d & (acc_d < len_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      acc_q        <= '0;
      sent_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      word_ready_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      sent_q       <= sent_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      word_ready_q <= word_ready_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_encrypter_out.sv
// Scoreboard bench for encrypter_out: expected bytes are queued as messages and words are
// issued; a monitor with a UART transmitter model pops and compares every tx_start.
module tb_encrypter_out;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 32;
`ifdef CRYPT_OUT_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  msg_len = '0;
  logic              fme_done = 1'b0;
  logic [WORD_W-1:0] fme_data_out = '0;
  logic              word_ready;
  logic              tx_busy = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic              done;
  logic              overrun;

  encrypter_out #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg_len      (msg_len),
    .fme_done     (fme_done),
    .fme_data_out (fme_data_out),
    .word_ready   (word_ready),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int rd_idx = 0;
  int n_tx = 0;
  int n_done = 0;
  int tx_len = 4;
  int tx_late = 0;
  int tx_wait = 0;
  int tx_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference framing: a word becomes four bytes, most significant first.
  task automatic push_word(input logic [WORD_W-1:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[WORD_W-1-8*i -: 8]);
  endtask

  task automatic start_msg(input int len);
    msg_len = LEN_W'(len);
    start   = 1'b1;
    if (HDR_WORDS != 0) push_word(WORD_W'(len));
    tick();
    start = 1'b0;
  endtask

  task automatic deliver(input logic [WORD_W-1:0] w);
    int n = 0;
    while (!word_ready && n < 400) begin
      tick();
      n++;
    end
    if (!word_ready) begin
      checks++;
      failures++;
      $display("FAIL word_ready_timeout actual=0 required=1");
    end else begin
      fme_done     = 1'b1;
      fme_data_out = w;
      push_word(w);
      tick();
      fme_done = 1'b0;
    end
  endtask

  task automatic wait_done();
    int base = n_done;
    int n = 0;
    while (n_done == base && n < 3000) begin
      tick();
      n++;
    end
    chk("done_pulse_count", 32'(n_done - base), 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Monitor plus UART transmitter model, sampled on the falling edge.
  task automatic mon_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_idx  = exp_q.size();
        tx_busy = 1'b0;
        tx_wait = 0;
        tx_left = 0;
      end else begin
        if (tx_left > 0) begin
          tx_left--;
          if (tx_left == 0) tx_busy = 1'b0;
        end
        if (tx_wait > 0) begin
          tx_wait--;
          if (tx_wait == 0) begin
            tx_busy = 1'b1;
            tx_left = tx_len;
          end
        end
        if (tx_start) begin
          n_tx++;
          chk("tx_start_while_tx_busy", {31'd0, tx_busy}, 32'd0);
          if (rd_idx < exp_q.size()) begin
            chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q[rd_idx]});
            rd_idx++;
          end else begin
            checks++;
            failures++;
            $display("FAIL tx_byte_unexpected actual=%0h required=none", tx_data);
          end
          tx_wait = 1 + tx_late;
        end
        if (done) begin
          n_done++;
          chk("done_stream_complete", 32'(rd_idx), 32'(exp_q.size()));
        end
      end
    end
  endtask

  initial begin
    int base_tx;
    int base_done;
    int n;
    int len;
    fork
      mon_loop();
    join_none

    // Reset values
    tick();
    tick();
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_word_ready", {31'd0, word_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // Two-word message with a slow transmitter
    tx_len = 10;
    tx_late = 0;
    base_tx = n_tx;
    start_msg(2);
    deliver(32'hDEADBEEF);
    deliver(32'h01020304);
    wait_done();
    chk("msg2_byte_count", 32'(n_tx - base_tx), 32'(4 * (2 + HDR_WORDS)));

    // Single word delivered while tx is idle
    tx_len = 3;
    base_tx = n_tx;
    start_msg(1);
`ifndef CRYPT_OUT_HEADER_EN
    repeat (3) tick();
    chk("lat_word_ready", {31'd0, word_ready}, 32'd1);
    fme_done     = 1'b1;
    fme_data_out = 32'hA5A50F0F;
    push_word(32'hA5A50F0F);
    tick();
    fme_done = 1'b0;
    chk("lat_tx_start_c1", {31'd0, tx_start}, 32'd0);
    tick();
    chk("lat_tx_start_c2", {31'd0, tx_start}, 32'd1);
`else
    deliver(32'hA5A50F0F);
`endif
    wait_done();
    chk("msg1_byte_count", 32'(n_tx - base_tx), 32'(4 * (1 + HDR_WORDS)));

    // Overrun: second delivery while the holding register is still full
    base_tx = n_tx;
    start_msg(2);
    deliver(32'h11111111);
    fme_done     = 1'b1;
    fme_data_out = 32'h22222222;
    tick();
    fme_done = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    deliver(32'h33333333);
    wait_done();
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    chk("overrun_byte_count", 32'(n_tx - base_tx), 32'(4 * (2 + HDR_WORDS)));

    // Zero-length message; its start also clears overrun
    base_tx = n_tx;
    base_done = n_done;
    start_msg(0);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);
`ifndef CRYPT_OUT_HEADER_EN
    chk("len0_done_c1", {31'd0, done}, 32'd0);
    tick();
    chk("len0_done_c2", {31'd0, done}, 32'd1);
    tick();
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_done_count", 32'(n_done - base_done), 32'd1);
`else
    wait_done();
`endif
    chk("len0_byte_count", 32'(n_tx - base_tx), 32'(4 * HDR_WORDS));

    // Reset after two bytes of a message
    tx_len = 4;
    base_tx = n_tx;
    start_msg(2);
    deliver(32'hCAFEF00D);
    n = 0;
    while ((n_tx - base_tx) < 2 && n < 400) begin
      tick();
      n++;
    end
    chk("mid_rst_two_bytes", 32'(n_tx - base_tx), 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_word_ready", {31'd0, word_ready}, 32'd0);
    rst = 1'b0;
    tick();
    base_tx = n_tx;
    start_msg(1);
    deliver(32'h55667788);
    wait_done();
    chk("post_rst_byte_count", 32'(n_tx - base_tx), 32'(4 * (1 + HDR_WORDS)));

    // Late tx_busy plus a start pulse while busy
    tx_len = 5;
    tx_late = 1;
    base_tx = n_tx;
    base_done = n_done;
    start_msg(3);
    deliver(32'h0A0B0C0D);
    repeat (3) tick();
    msg_len = LEN_W'(9);
    start   = 1'b1;
    tick();
    start = 1'b0;
    deliver(32'h10203040);
    deliver(32'hF0E0D0C0);
    wait_done();
    repeat (20) tick();
    chk("late_byte_count", 32'(n_tx - base_tx), 32'(4 * (3 + HDR_WORDS)));
    chk("late_single_done", 32'(n_done - base_done), 32'd1);

    // Randomized messages
    for (int m = 0; m < 8; m++) begin
      len     = int'($urandom_range(0, 4));
      tx_len  = int'($urandom_range(1, 8));
      tx_late = int'($urandom_range(0, 1));
      base_tx = n_tx;
      start_msg(len);
      for (int w = 0; w < len; w++) begin
        repeat ($urandom_range(0, 15)) tick();
        deliver($urandom);
      end
      wait_done();
      chk("rand_byte_count", 32'(n_tx - base_tx), 32'(4 * (len + HDR_WORDS)));
      chk("rand_overrun", {31'd0, overrun}, 32'd0);
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
